// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS IF/ID and ID/EX stage registers.
// Holds control-word bit positions, instruction field ranges and the
// NOP encoding. It has no ports and is imported by the pipeline modules.
package mips_pipe_pkg;

    // Control-word bit positions (decoder layout)
    localparam int CW_MEM_WRITE_BIT  = 5;
    localparam int CW_MEM_READ_BIT   = 6;
    localparam int CW_REG_WRITE_BIT  = 7;
    localparam int CW_JAL_BIT        = 8;
    localparam int CW_JMP_CTL_LSB    = 9;
    localparam int CW_JMP_CTL_MSB    = 10;

    // Instruction register-field ranges
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/mips_pipe_reg.sv
// Generic pipeline register: async active-high reset, load enable and
// synchronous flush-to-zero. Flush takes priority over enable.
// Ports: clk, reset, en_i (load), flush_i (clear), d_i / q_o (N_BITS data).
module mips_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              flush_i,
    input  logic [N_BITS-1:0] d_i,
    output logic [N_BITS-1:0] q_o
);

    logic [N_BITS-1:0] data_q;
    logic [N_BITS-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (flush_i) begin
            data_d = '0;
        end else if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/mips_hazard_pipe_ctrl.sv
// IF/ID and ID/EX stage registers with load-use stall, EX-resolved
// redirect flush and saturating stall/flush event counters.
// Ports:
//   clk, reset                    - clock, async active-high reset
//   if_*_i                        - fetched instruction and PC+4
//   id_*_i                        - decode-stage control, reg reads, immediate
//   ex_redirect_i                 - EX resolved a taken branch / jump
//   pc_enable_o                   - PC write enable (low while stalling)
//   id_*_o, ex_*_o                - stage register contents and valid bits
//   stall_count_o, flush_count_o  - saturating event counters
module mips_hazard_pipe_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CTRL_WIDTH    = 15,
    parameter int MEM_READ_BIT  = CW_MEM_READ_BIT,
    parameter int REG_WRITE_BIT = CW_REG_WRITE_BIT,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  if_instruction_i,
    input  logic [DATA_WIDTH-1:0]  if_pc_plus_4_i,
    input  logic [CTRL_WIDTH-1:0]  id_control_i,
    input  logic [DATA_WIDTH-1:0]  id_read_data_1_i,
    input  logic [DATA_WIDTH-1:0]  id_read_data_2_i,
    input  logic [DATA_WIDTH-1:0]  id_imm_ext_i,
    input  logic                   ex_redirect_i,
    output logic                   pc_enable_o,
    output logic [DATA_WIDTH-1:0]  id_instruction_o,
    output logic [DATA_WIDTH-1:0]  id_pc_plus_4_o,
    output logic                   id_valid_o,
    output logic [DATA_WIDTH-1:0]  ex_instruction_o,
    output logic [DATA_WIDTH-1:0]  ex_pc_plus_4_o,
    output logic [DATA_WIDTH-1:0]  ex_read_data_1_o,
    output logic [DATA_WIDTH-1:0]  ex_read_data_2_o,
    output logic [DATA_WIDTH-1:0]  ex_imm_ext_o,
    output logic [CTRL_WIDTH-1:0]  ex_control_o,
    output logic                   ex_valid_o,
    output logic [COUNT_WIDTH-1:0] stall_count_o,
    output logic [COUNT_WIDTH-1:0] flush_count_o
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0] id_instr_q, id_pc4_q;
    logic                  id_valid_q;
    logic [DATA_WIDTH-1:0] ex_instr_q, ex_pc4_q, ex_rd1_q, ex_rd2_q, ex_imm_q;
    logic [CTRL_WIDTH-1:0] ex_ctrl_q, ex_ctrl_d;
    logic                  ex_valid_q;

    logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic [COUNT_WIDTH-1:0] flush_count_q, flush_count_d;

    reg_idx_t rt_ex, rs_id, rt_id;
    logic     load_use, redirect, stall;

    assign rt_ex = ex_instr_q[RT_MSB:RT_LSB];
    assign rs_id = id_instr_q[RS_MSB:RS_LSB];
    assign rt_id = id_instr_q[RT_MSB:RT_LSB];

    assign load_use = ex_valid_q & ex_ctrl_q[MEM_READ_BIT] & id_valid_q &
                      (rt_ex != '0) & ((rt_ex == rs_id) | (rt_ex == rt_id));
    // A redirect squashes the dependent instruction anyway, so it masks the stall.
    assign redirect = ex_redirect_i & ex_valid_q;
    assign stall    = load_use & ~redirect;

    assign pc_enable_o = ~stall;

    // An invalid ID slot must never carry side-effecting control into EX.
    assign ex_ctrl_d = id_valid_q ? id_control_i : '0;

    // IF/ID: hold on stall, clear on redirect
    mips_pipe_reg #(.N_BITS(DATA_WIDTH)) u_id_instr (
        .clk(clk), .reset(reset), .en_i(~stall), .flush_i(redirect),
        .d_i(if_instruction_i), .q_o(id_instr_q));
    mips_pipe_reg #(.N_BITS(DATA_WIDTH)) u_id_pc4 (
        .clk(clk), .reset(reset), .en_i(~stall), .flush_i(redirect),
        .d_i(if_pc_plus_4_i), .q_o(id_pc4_q));
    mips_pipe_reg #(.N_BITS(1)) u_id_valid (
        .clk(clk), .reset(reset), .en_i(~stall), .flush_i(redirect),
        .d_i(1'b1), .q_o(id_valid_q));

    // ID/EX: always advances; bubble (all zero) on stall or redirect
    mips_pipe_reg #(.N_BITS(DATA_WIDTH)) u_ex_instr (
        .clk(clk), .reset(reset), .en_i(1'b1), .flush_i(redirect | stall),
        .d_i(id_instr_q), .q_o(ex_instr_q));
    mips_pipe_reg #(.N_BITS(DATA_WIDTH)) u_ex_pc4 (
        .clk(clk), .reset(reset), .en_i(1'b1), .flush_i(redirect | stall),
        .d_i(id_pc4_q), .q_o(ex_pc4_q));
    mips_pipe_reg #(.N_BITS(DATA_WIDTH)) u_ex_rd1 (
        .clk(clk), .reset(reset), .en_i(1'b1), .flush_i(redirect | stall),
        .d_i(id_read_data_1_i), .q_o(ex_rd1_q));
    mips_pipe_reg #(.N_BITS(DATA_WIDTH)) u_ex_rd2 (
        .clk(clk), .reset(reset), .en_i(1'b1), .flush_i(redirect | stall),
        .d_i(id_read_data_2_i), .q_o(ex_rd2_q));
    mips_pipe_reg #(.N_BITS(DATA_WIDTH)) u_ex_imm (
        .clk(clk), .reset(reset), .en_i(1'b1), .flush_i(redirect | stall),
        .d_i(id_imm_ext_i), .q_o(ex_imm_q));
    mips_pipe_reg #(.N_BITS(CTRL_WIDTH)) u_ex_ctrl (
        .clk(clk), .reset(reset), .en_i(1'b1), .flush_i(redirect | stall),
        .d_i(ex_ctrl_d), .q_o(ex_ctrl_q));
    mips_pipe_reg #(.N_BITS(1)) u_ex_valid (
        .clk(clk), .reset(reset), .en_i(1'b1), .flush_i(redirect | stall),
        .d_i(id_valid_q), .q_o(ex_valid_q));

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
        if (redirect && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign id_instruction_o = id_instr_q;
    assign id_pc_plus_4_o   = id_pc4_q;
    assign id_valid_o       = id_valid_q;
    assign ex_instruction_o = ex_instr_q;
    assign ex_pc_plus_4_o   = ex_pc4_q;
    assign ex_read_data_1_o = ex_rd1_q;
    assign ex_read_data_2_o = ex_rd2_q;
    assign ex_imm_ext_o     = ex_imm_q;
    assign ex_control_o     = ex_valid_q ? ex_ctrl_q : '0;
    assign ex_valid_o       = ex_valid_q;
    assign stall_count_o    = stall_count_q;
    assign flush_count_o    = flush_count_q;

endmodule

// File: tb/tb_mips_hazard_pipe_ctrl.sv
// Self-checking bench for mips_hazard_pipe_ctrl (COUNT_WIDTH=2 so that
// counter saturation is reachable). A tiny program-counter model feeds
// the fetch port; every fetched word is queued and compared when it
// shows up as a valid instruction in EX.
module tb_mips_hazard_pipe_ctrl;

    localparam int DW = 32;
    localparam int CW = 15;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] if_instruction_i = '0;
    logic [DW-1:0] if_pc_plus_4_i = '0;
    logic [CW-1:0] id_control_i;
    logic [DW-1:0] id_read_data_1_i, id_read_data_2_i, id_imm_ext_i;
    logic          ex_redirect_i = 1'b0;
    logic          pc_enable_o;
    logic [DW-1:0] id_instruction_o, id_pc_plus_4_o;
    logic          id_valid_o;
    logic [DW-1:0] ex_instruction_o, ex_pc_plus_4_o, ex_read_data_1_o, ex_read_data_2_o, ex_imm_ext_o;
    logic [CW-1:0] ex_control_o;
    logic          ex_valid_o;
    logic [NW-1:0] stall_count_o, flush_count_o;

    always #5 clk = ~clk;

    // Decoder model: lw -> mem_read(6)+reg_write(7); R-type -> reg_write; beq -> bit0
    function automatic logic [CW-1:0] dec(input logic [DW-1:0] i);
        logic [CW-1:0] c;
        c = '0;
        case (i[31:26])
            6'h23: begin c[6] = 1'b1; c[7] = 1'b1; end
            6'h00: c[7] = 1'b1;
            6'h04: c[0] = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction
    function automatic logic [DW-1:0] rd1_of(input logic [DW-1:0] i); return i ^ 32'hA5A5_A5A5; endfunction
    function automatic logic [DW-1:0] rd2_of(input logic [DW-1:0] i); return i ^ 32'h5A5A_5A5A; endfunction
    function automatic logic [DW-1:0] imm_of(input logic [DW-1:0] i); return {{16{i[15]}}, i[15:0]}; endfunction
    function automatic logic [DW-1:0] mk_r(input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction
    function automatic logic [DW-1:0] mk_lw(input int rt, input int rs);
        return {6'h23, 5'(rs), 5'(rt), 16'h0000};
    endfunction
    function automatic logic [DW-1:0] mk_beq(input int rs, input int rt);
        return {6'h04, 5'(rs), 5'(rt), 16'h0004};
    endfunction

    assign id_control_i     = dec(id_instruction_o);
    assign id_read_data_1_i = rd1_of(id_instruction_o);
    assign id_read_data_2_i = rd2_of(id_instruction_o);
    assign id_imm_ext_i     = imm_of(id_instruction_o);

    mips_hazard_pipe_ctrl #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .MEM_READ_BIT(6), .REG_WRITE_BIT(7), .COUNT_WIDTH(NW)
    ) dut (
        .clk(clk), .reset(reset),
        .if_instruction_i(if_instruction_i), .if_pc_plus_4_i(if_pc_plus_4_i),
        .id_control_i(id_control_i), .id_read_data_1_i(id_read_data_1_i),
        .id_read_data_2_i(id_read_data_2_i), .id_imm_ext_i(id_imm_ext_i),
        .ex_redirect_i(ex_redirect_i), .pc_enable_o(pc_enable_o),
        .id_instruction_o(id_instruction_o), .id_pc_plus_4_o(id_pc_plus_4_o),
        .id_valid_o(id_valid_o), .ex_instruction_o(ex_instruction_o),
        .ex_pc_plus_4_o(ex_pc_plus_4_o), .ex_read_data_1_o(ex_read_data_1_o),
        .ex_read_data_2_o(ex_read_data_2_o), .ex_imm_ext_o(ex_imm_ext_o),
        .ex_control_o(ex_control_o), .ex_valid_o(ex_valid_o),
        .stall_count_o(stall_count_o), .flush_count_o(flush_count_o)
    );

    typedef struct {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc4;
        int            fedge;
    } sb_t;

    sb_t           sb[$];
    logic [DW-1:0] prog[$];
    int            pc_idx, target_idx, edge_n, n_stall_seen, n_pop;
    int            errors = 0;
    int            checks = 0;
    logic          force_redir, chk_lat, last_en;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // One clock: drive fetch/redirect at negedge, advance PC model after posedge,
    // then compare whatever sits in EX against the queue.
    task automatic cycle();
        logic en, redir;
        sb_t  e;
        @(negedge clk);
        if_instruction_i = (pc_idx < prog.size()) ? prog[pc_idx] : 32'h0;
        if_pc_plus_4_i   = 32'((pc_idx + 1) * 4);
        ex_redirect_i    = force_redir || (ex_valid_o && ex_instruction_o[31:26] == 6'h04);
        #1;
        en    = pc_enable_o;
        redir = ex_redirect_i && ex_valid_o;
        if (!en) n_stall_seen++;
        @(posedge clk);
        edge_n++;
        #1;
        if (redir) begin
            sb.delete();
            pc_idx = target_idx;
        end else if (en) begin
            sb.push_back('{instr: if_instruction_i, pc4: if_pc_plus_4_i, fedge: edge_n});
            pc_idx++;
        end
        if (ex_valid_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: ex holds %h, required nothing valid", ex_instruction_o);
            end else begin
                e = sb.pop_front();
                n_pop++;
                checks++;
                if (ex_instruction_o !== e.instr || ex_pc_plus_4_o !== e.pc4 ||
                    ex_control_o !== dec(e.instr) || ex_read_data_1_o !== rd1_of(e.instr) ||
                    ex_read_data_2_o !== rd2_of(e.instr) || ex_imm_ext_o !== imm_of(e.instr)) begin
                    errors++;
                    $display("FAIL ex_fields: got instr=%h pc4=%h ctl=%h rd1=%h rd2=%h imm=%h, required instr=%h pc4=%h ctl=%h",
                             ex_instruction_o, ex_pc_plus_4_o, ex_control_o, ex_read_data_1_o,
                             ex_read_data_2_o, ex_imm_ext_o, e.instr, e.pc4, dec(e.instr));
                end
                if (chk_lat) begin
                    checks++;
                    if (edge_n - e.fedge !== 1) begin
                        errors++;
                        $display("FAIL latency: got %0d edges, required 1", edge_n - e.fedge);
                    end
                end
            end
        end else begin
            checks++;
            if (ex_control_o !== '0) begin
                errors++;
                $display("FAIL ex_ctl_invalid: got %h, required 0", ex_control_o);
            end
        end
        last_en = en;
    endtask

    // Reset held over one rising edge, released just after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        force_redir = 1'b0;
        ex_redirect_i = 1'b0;
        chk_lat = 1'b0;
        pc_idx = 0; target_idx = 0; edge_n = 0; n_stall_seen = 0; n_pop = 0;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        prog = '{mk_r(16, 17, 18)};
        do_reset();
        checks++;
        if (pc_enable_o !== 1'b1 || id_valid_o !== 1'b0 || ex_valid_o !== 1'b0 ||
            ex_control_o !== '0 || id_instruction_o !== '0 || stall_count_o !== '0 || flush_count_o !== '0) begin
            errors++;
            $display("FAIL reset_state: pc_en=%b idv=%b exv=%b ctl=%h idi=%h sc=%0d fc=%0d, required 1 0 0 0 0 0 0",
                     pc_enable_o, id_valid_o, ex_valid_o, ex_control_o, id_instruction_o, stall_count_o, flush_count_o);
        end
        cycle();
        checks++;
        if (id_valid_o !== 1'b1 || id_instruction_o !== prog[0]) begin
            errors++;
            $display("FAIL first_fetch: idv=%b idi=%h, required 1 %h", id_valid_o, id_instruction_o, prog[0]);
        end
    endtask

    task automatic test_straight_line();
        prog = '{mk_r(16,17,18), mk_r(19,20,21), mk_r(22,23,24), mk_r(25,26,27), mk_r(1,2,3), mk_r(4,5,6)};
        do_reset();
        chk_lat = 1'b1;
        for (int k = 0; k < 9; k++) cycle();
        chk_lat = 1'b0;
        checks++;
        if (n_stall_seen !== 0 || n_pop !== 8) begin
            errors++;
            $display("FAIL straight_flow: stalls=%0d pops=%0d, required 0 8", n_stall_seen, n_pop);
        end
        checks++;
        if (stall_count_o !== '0 || flush_count_o !== '0) begin
            errors++;
            $display("FAIL straight_counts: sc=%0d fc=%0d, required 0 0", stall_count_o, flush_count_o);
        end
    endtask

    task automatic test_load_use();
        prog = '{mk_lw(8, 0), mk_r(8, 8, 9), mk_r(16, 17, 18)};
        do_reset();
        cycle(); cycle();
        checks++;
        if (pc_enable_o !== 1'b0) begin
            errors++;
            $display("FAIL lu_pc_en: got %b, required 0", pc_enable_o);
        end
        cycle();
        checks++;
        if (last_en !== 1'b0 || ex_valid_o !== 1'b0 || stall_count_o !== 2'd1 || id_instruction_o !== prog[1]) begin
            errors++;
            $display("FAIL lu_bubble: en=%b exv=%b sc=%0d idi=%h, required 0 0 1 %h",
                     last_en, ex_valid_o, stall_count_o, id_instruction_o, prog[1]);
        end
        cycle();
        checks++;
        if (ex_valid_o !== 1'b1 || ex_instruction_o !== prog[1] || pc_enable_o !== 1'b1) begin
            errors++;
            $display("FAIL lu_dep_in_ex: exv=%b exi=%h pc_en=%b, required 1 %h 1",
                     ex_valid_o, ex_instruction_o, pc_enable_o, prog[1]);
        end
        cycle(); cycle();
        checks++;
        if (stall_count_o !== 2'd1 || n_stall_seen !== 1) begin
            errors++;
            $display("FAIL lu_count: sc=%0d seen=%0d, required 1 1", stall_count_o, n_stall_seen);
        end
    endtask

    task automatic test_load_zero_reg();
        prog = '{mk_lw(0, 0), mk_r(0, 0, 9), mk_r(16, 17, 18)};
        do_reset();
        for (int k = 0; k < 5; k++) cycle();
        checks++;
        if (stall_count_o !== '0 || n_stall_seen !== 0) begin
            errors++;
            $display("FAIL lw_zero: sc=%0d seen=%0d, required 0 0", stall_count_o, n_stall_seen);
        end
    endtask

    task automatic test_redirect();
        prog = '{mk_beq(1, 1), mk_r(16,17,18), mk_r(19,20,21), mk_r(22,23,24), mk_r(1,2,3), mk_r(4,5,6)};
        do_reset();
        target_idx = 4;
        cycle(); cycle(); cycle();
        checks++;
        if (id_valid_o !== 1'b0 || ex_valid_o !== 1'b0 || ex_control_o !== '0 ||
            id_instruction_o !== '0 || ex_instruction_o !== '0 || flush_count_o !== 2'd1) begin
            errors++;
            $display("FAIL redirect_flush: idv=%b exv=%b ctl=%h idi=%h exi=%h fc=%0d, required 0 0 0 0 0 1",
                     id_valid_o, ex_valid_o, ex_control_o, id_instruction_o, ex_instruction_o, flush_count_o);
        end
        cycle(); cycle();
        checks++;
        if (ex_valid_o !== 1'b1 || ex_instruction_o !== prog[4]) begin
            errors++;
            $display("FAIL redirect_target: exv=%b exi=%h, required 1 %h", ex_valid_o, ex_instruction_o, prog[4]);
        end
        cycle();
    endtask

    task automatic test_redirect_ignored();
        prog = '{mk_r(16,17,18), mk_r(19,20,21), mk_r(22,23,24)};
        do_reset();
        force_redir = 1'b1;
        cycle(); cycle();
        force_redir = 1'b0;
        checks++;
        if (flush_count_o !== '0 || id_valid_o !== 1'b1 || id_instruction_o !== prog[1]) begin
            errors++;
            $display("FAIL redirect_ignored: fc=%0d idv=%b idi=%h, required 0 1 %h",
                     flush_count_o, id_valid_o, id_instruction_o, prog[1]);
        end
        cycle();
    endtask

    task automatic test_redirect_vs_load_use();
        prog = '{mk_lw(8, 0), mk_r(8, 8, 9), mk_r(16,17,18), mk_r(19,20,21), mk_r(1,2,3)};
        do_reset();
        target_idx = 4;
        cycle(); cycle();
        force_redir = 1'b1;
        cycle();
        force_redir = 1'b0;
        checks++;
        if (last_en !== 1'b1 || flush_count_o !== 2'd1 || stall_count_o !== '0 || id_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_priority: en=%b fc=%0d sc=%0d idv=%b, required 1 1 0 0",
                     last_en, flush_count_o, stall_count_o, id_valid_o);
        end
        cycle(); cycle();
    endtask

    task automatic test_back_to_back();
        prog = '{mk_lw(8, 0), mk_lw(9, 8), mk_lw(10, 9), mk_lw(11, 10), mk_lw(12, 11), mk_r(12, 12, 13)};
        do_reset();
        for (int k = 0; k < 14; k++) cycle();
        checks++;
        if (n_stall_seen !== 5 || stall_count_o !== 2'd3) begin
            errors++;
            $display("FAIL stall_saturate: seen=%0d sc=%0d, required 5 3", n_stall_seen, stall_count_o);
        end
        checks++;
        if (sb.size() === 0 || n_pop !== 8) begin
            errors++;
            $display("FAIL b2b_flow: pops=%0d, required 8", n_pop);
        end
    endtask

    task automatic test_reset_mid_stall();
        prog = '{mk_lw(8, 0), mk_r(8, 8, 9)};
        do_reset();
        cycle(); cycle();
        checks++;
        if (pc_enable_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_stall_setup: pc_en=%b, required 0", pc_enable_o);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (pc_enable_o !== 1'b1 || id_valid_o !== 1'b0 || ex_valid_o !== 1'b0 || id_instruction_o !== '0 ||
            ex_instruction_o !== '0 || ex_control_o !== '0 || ex_read_data_1_o !== '0 ||
            stall_count_o !== '0 || flush_count_o !== '0) begin
            errors++;
            $display("FAIL mid_stall_reset: pc_en=%b idv=%b exv=%b idi=%h exi=%h ctl=%h rd1=%h sc=%0d fc=%0d, required 1 and all 0",
                     pc_enable_o, id_valid_o, ex_valid_o, id_instruction_o, ex_instruction_o,
                     ex_control_o, ex_read_data_1_o, stall_count_o, flush_count_o);
        end
        do_reset();
    endtask

    initial begin
        force_redir = 1'b0;
        chk_lat = 1'b0;
        last_en = 1'b1;
        test_reset();
        test_straight_line();
        test_load_use();
        test_load_zero_reg();
        test_redirect();
        test_redirect_ignored();
        test_redirect_vs_load_use();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_hazard_pipe_ctrl.md
# mips_hazard_pipe_ctrl

Parametrised IF/ID and ID/EX pipeline register bank with hazard control for the five-stage MIPS core. Replaces the free-running, always-enabled stage registers between fetch, decode and execute. Adds:
- a valid bit per stage;
- load-use stall with bubble insertion;
- flush of younger stages on a taken branch or jump resolved in EX;
- saturating stall and flush performance counters.

## Interface
Parameters:
- DATA_WIDTH, 32, width of instruction, PC+4, register-read and immediate paths
- CTRL_WIDTH, 15, width of the decoded control word carried into EX
- MEM_READ_BIT, 6, index of mem_read inside the control word
- REG_WRITE_BIT, 7, index of reg_write inside the control word
- COUNT_WIDTH, 16, width of each performance counter

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- if_instruction_i  in  DATA_WIDTH  instruction fetched at current PC
- if_pc_plus_4_i  in  DATA_WIDTH  PC+4 of fetched instruction
- id_control_i  in  CTRL_WIDTH  control word decoded from id_instruction_o
- id_read_data_1_i, id_read_data_2_i  in  DATA_WIDTH  register-file reads for rs/rt of id_instruction_o
- id_imm_ext_i  in  DATA_WIDTH  extended immediate of id_instruction_o
- ex_redirect_i  in  1  EX resolved a taken branch or any jump (j/jal/jr)
- pc_enable_o  out  1  PC write enable
- id_instruction_o, id_pc_plus_4_o  out  DATA_WIDTH  IF/ID contents
- id_valid_o  out  1  IF/ID holds a live instruction
- ex_instruction_o, ex_pc_plus_4_o, ex_read_data_1_o, ex_read_data_2_o, ex_imm_ext_o  out  DATA_WIDTH  ID/EX contents
- ex_control_o  out  CTRL_WIDTH  ID/EX control; all-zero when not valid
- ex_valid_o  out  1  ID/EX holds a live instruction
- stall_count_o, flush_count_o  out  COUNT_WIDTH  saturating event counters

## Operation
Load-use hazard:
- Definition: ex_valid & ex_control[MEM_READ_BIT] & id_valid & (rt_ex != 0) & (rt_ex == rs_id | rt_ex == rt_id).
- rt_ex = ex_instruction[20:16]; rs_id/rt_id = id_instruction[25:21]/[20:16].
- On a hazard: pc_enable_o=0, IF/ID holds its contents, ID/EX loads a bubble.
- Bubble: all ID/EX fields 0, valid 0.

Redirect:
- Definition: ex_redirect_i & ex_valid.
- IF/ID is flushed (instruction 0, valid 0); ID/EX loads a bubble; pc_enable_o=1.
- Redirect has priority over the load-use hazard. A stall does not fire in the same cycle.

Normal advance:
- IF/ID <= {if_instruction_i, if_pc_plus_4_i, valid 1}.
- ID/EX <= ID-stage inputs, with valid = id_valid.
- Exception: if id_valid=0, ex_control loads 0 regardless of id_control_i.

Counters:
- stall_count increments on each stall cycle.
- flush_count increments on each redirect cycle.
- Both saturate at 2^COUNT_WIDTH-1 with no wrap.

Invalid-instruction side effects:
- ex_control_o is forced 0 when ex_valid=0.
- This guarantees no reg_write or mem_write from an invalid instruction.

## Timing
- All stage registers and counters update on the rising edge of clk.
- pc_enable_o is combinational from the current registered state and ex_redirect_i. No internal latency beyond one cycle per stage.
- Load-use costs exactly one bubble. The dependent instruction enters EX two cycles after the load.
- Redirect costs two squashed instructions.
- Reset (asynchronous, any time, including mid-stall): all registers and counters 0, id_valid=ex_valid=0. pc_enable_o then evaluates to 1.
- First fetched instruction is valid in IF/ID one edge after reset deasserts.
- ex_redirect_i while ex_valid=0 is ignored and not counted.
- Back-to-back load-use is handled: a second load that is itself dependent stalls again once it reaches EX.

## Structure
- Shared package mips_pipe_pkg:
  - control-word bit indices (MEM_READ_BIT, REG_WRITE_BIT, MEM_WRITE, JAL, JMP_CTL)
  - field ranges for rs/rt/rd
  - NOP instruction constant 32'h0
- One sub-module: mips_pipe_reg, a generic N_BITS register with async reset, enable and synchronous flush-to-zero. Flush dominates enable.
- One instance of mips_pipe_reg per stage field.
- Hazard and redirect logic plus counters live in the top of this block.

## Test plan
- Straight-line code, no hazards: 6 instructions in, each appears on ex_instruction_o 2 cycles after fetch; pc_enable_o=1 throughout; both counters 0.
- lw $t0,0($zero) then add $t1,$t0,$t0: one cycle with pc_enable_o=0 and ex_valid_o=0; add reaches EX one cycle later; stall_count_o=1.
- lw $t0 then add using $zero as rt_ex target (lw $0): no stall, stall_count_o=0.
- Taken beq in EX (ex_redirect_i=1, ex_valid=1): next cycle id_valid_o=0 and ex_valid_o=0 with ex_control_o=0; flush_count_o=1.
- Redirect and load-use in the same cycle: flush wins, pc_enable_o=1; flush_count_o=1, stall_count_o=0.
- COUNT_WIDTH=2, 5 consecutive stalls: stall_count_o stops at 3. Reset asserted mid-stall: all outputs 0 at once, pc_enable_o=1.
